// File: rtl/prq_pkg.sv
// Shared types and default widths for the pixel reorder queue.
// prq_entry_t is the entry layout (colour, x, y) at the default widths.
package prq_pkg;

  localparam int PRQ_DATA_WIDTH = 32;
  localparam int PRQ_RBG_SIZE   = 24;
  localparam int PRQ_DEPTH      = 8;

  typedef struct packed {
    logic [PRQ_RBG_SIZE-1:0]   colour;
    logic [PRQ_DATA_WIDTH-1:0] x;
    logic [PRQ_DATA_WIDTH-1:0] y;
  } prq_entry_t;

endpackage

// File: rtl/prq_match_unit.sv
// Coordinate comparator array plus lowest-index priority encoder.
// Build option PRQ_ANY_MATCH_EN: when defined every stored entry may match
// (out-of-order reorder buffer); when undefined only the head entry (index 0)
// is eligible, so a match further back reports no hit (in-order queue).
module prq_match_unit
  import prq_pkg::*;
#(
  parameter int DATA_WIDTH = PRQ_DATA_WIDTH,
  parameter int DEPTH      = PRQ_DEPTH,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [DATA_WIDTH-1:0] x_i [DEPTH],
  input  logic [DATA_WIDTH-1:0] y_i [DEPTH],
  input  logic [DATA_WIDTH-1:0] xpixel_check,
  input  logic [DATA_WIDTH-1:0] ypixel_check,
  output logic                  hit,
  output logic [IDX_W-1:0]      hit_idx
);

`ifdef PRQ_ANY_MATCH_EN
  localparam logic [DEPTH-1:0] SEARCH_MASK = {DEPTH{1'b1}};
`else
  localparam logic [DEPTH-1:0] SEARCH_MASK = {{(DEPTH-1){1'b0}}, 1'b1};
`endif

  logic [DEPTH-1:0] match_s;

  // Compare the requested coordinate against every valid, searchable entry.
  always_comb begin
    match_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_i[i] && (x_i[i] == xpixel_check) && (y_i[i] == ypixel_check);
    end
    match_s = match_s & SEARCH_MASK;
  end

  // Pick the lowest matching index so the oldest duplicate wins.
  always_comb begin
    hit     = |match_s;
    hit_idx = {IDX_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hit_idx = match_s[i] ? IDX_W'(i) : hit_idx;
    end
  end

endmodule

// File: rtl/pixel_reorder_queue.sv
// Pixel reorder queue: compacted entry storage (index 0 oldest), removal by
// coordinate lookup with shift-down, occupancy count and registered outputs.
// Build option PRQ_ANY_MATCH_EN selects any-entry search (see prq_match_unit).
module pixel_reorder_queue
  import prq_pkg::*;
#(
  parameter int DATA_WIDTH = PRQ_DATA_WIDTH,
  parameter int RBG_SIZE   = PRQ_RBG_SIZE,
  parameter int DEPTH      = PRQ_DEPTH,
  parameter int COUNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RBG_SIZE-1:0]   colour_i,
  input  logic [DATA_WIDTH-1:0] xpixel_i,
  input  logic [DATA_WIDTH-1:0] ypixel_i,
  input  logic                  chk_valid,
  input  logic [DATA_WIDTH-1:0] xpixel_check,
  input  logic [DATA_WIDTH-1:0] ypixel_check,
  output logic [RBG_SIZE-1:0]   colour_o,
  output logic                  out_valid,
  output logic                  out_miss,
  output logic                  full_queue,
  output logic                  empty,
  output logic [COUNT_W-1:0]    count
);

  localparam int                 IDX_W      = $clog2(DEPTH);
  localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(DEPTH);

  typedef struct packed {
    logic [RBG_SIZE-1:0]   colour;
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
  } entry_t;

  entry_t                entries_q [DEPTH];
  entry_t                entries_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d, valid_up_s;
  logic [COUNT_W-1:0]    count_q, count_d, wr_idx_s;
  logic [RBG_SIZE-1:0]   colour_q, colour_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_miss_q, out_miss_d;
  logic                  push_s, hit_s, match_hit_s;
  logic [IDX_W-1:0]      match_idx_s;
  logic [DATA_WIDTH-1:0] x_s [DEPTH];
  logic [DATA_WIDTH-1:0] y_s [DEPTH];

  // Present stored coordinates to the comparator array.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      x_s[i] = entries_q[i].x;
      y_s[i] = entries_q[i].y;
    end
  end

  prq_match_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_match (
    .valid_i      (valid_q),
    .x_i          (x_s),
    .y_i          (y_s),
    .xpixel_check (xpixel_check),
    .ypixel_check (ypixel_check),
    .hit          (match_hit_s),
    .hit_idx      (match_idx_s)
  );

  // Full blocks a push even when a same-cycle hit frees a slot.
  assign in_ready = (count_q != COUNT_FULL);
  assign push_s   = in_valid && in_ready;
  assign hit_s    = chk_valid && match_hit_s;

  // Next-state: shift above the hit, append the push after any shift, update count.
  always_comb begin
    valid_up_s = {1'b0, valid_q[DEPTH-1:1]};
    wr_idx_s   = hit_s ? (count_q - COUNT_W'(1)) : count_q;
    valid_d    = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (push_s && (int'(wr_idx_s) == i)) begin
        entries_d[i] = '{colour: colour_i, x: xpixel_i, y: ypixel_i};
        valid_d[i]   = 1'b1;
      end else if (hit_s && (i >= int'(match_idx_s))) begin
        entries_d[i] = entries_q[(i == DEPTH - 1) ? i : i + 1];
        valid_d[i]   = valid_up_s[i];
      end else begin
        entries_d[i] = entries_q[i];
        valid_d[i]   = valid_q[i];
      end
    end

    if (hit_s) begin
      colour_d = entries_q[match_idx_s].colour;
    end else begin
      colour_d = colour_q;
    end
    out_valid_d = hit_s;
    out_miss_d  = chk_valid && !hit_s;

    case ({push_s, hit_s})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: valid bits, count and output registers; reset discards any push/request.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= {DEPTH{1'b0}};
      count_q     <= {COUNT_W{1'b0}};
      colour_q    <= {RBG_SIZE{1'b0}};
      out_valid_q <= 1'b0;
      out_miss_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      count_q     <= count_d;
      colour_q    <= colour_d;
      out_valid_q <= out_valid_d;
      out_miss_q  <= out_miss_d;
    end
  end

  // Entry payload storage; contents behind cleared valid bits are don't-care.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  assign colour_o   = colour_q;
  assign out_valid  = out_valid_q;
  assign out_miss   = out_miss_q;
  assign count      = count_q;
  assign full_queue = (count_q == COUNT_FULL);
  assign empty      = (count_q == {COUNT_W{1'b0}});

endmodule

// File: tb/tb_pixel_reorder_queue.sv
// Directed bench for pixel_reorder_queue at DEPTH=4. Expected values follow
// the build mode: any-entry search when PRQ_ANY_MATCH_EN is defined,
// head-only search otherwise.
module tb_pixel_reorder_queue;
  import prq_pkg::*;

`ifdef PRQ_ANY_MATCH_EN
  localparam bit ANY_MODE = 1'b1;
`else
  localparam bit ANY_MODE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] colour_i;
  logic [31:0] xpixel_i, ypixel_i;
  logic        chk_valid;
  logic [31:0] xpixel_check, ypixel_check;
  logic [23:0] colour_o;
  logic        out_valid, out_miss, full_queue, empty;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  pixel_reorder_queue #(
    .DATA_WIDTH (32),
    .RBG_SIZE   (24),
    .DEPTH      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .colour_i     (colour_i),
    .xpixel_i     (xpixel_i),
    .ypixel_i     (ypixel_i),
    .chk_valid    (chk_valid),
    .xpixel_check (xpixel_check),
    .ypixel_check (ypixel_check),
    .colour_o     (colour_o),
    .out_valid    (out_valid),
    .out_miss     (out_miss),
    .full_queue   (full_queue),
    .empty        (empty),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic prq_entry_t ent(input logic [31:0] x, input logic [31:0] y, input logic [23:0] c);
    prq_entry_t e;
    e.x = x;
    e.y = y;
    e.colour = c;
    return e;
  endfunction

  // One clock: apply inputs, sample 1 time unit after the edge, then release.
  task automatic drive(input bit rst, input bit iv, input prq_entry_t e,
                       input bit cv, input logic [31:0] cx, input logic [31:0] cy);
    reset        = rst;
    in_valid     = iv;
    colour_i     = e.colour;
    xpixel_i     = e.x;
    ypixel_i     = e.y;
    chk_valid    = cv;
    xpixel_check = cx;
    ypixel_check = cy;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    in_valid  = 1'b0;
    chk_valid = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, ent(32'd0, 32'd0, 24'h0), 1'b0, 32'd0, 32'd0);
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [23:0] c);
    drive(1'b0, 1'b1, ent(x, y, c), 1'b0, 32'd0, 32'd0);
  endtask

  task automatic req(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input logic ev, input logic em, input logic [23:0] ec, input logic [2:0] en);
    drive(1'b0, 1'b0, ent(32'd0, 32'd0, 24'h0), 1'b1, x, y);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'(ev));
    check_eq({tag, "_miss"}, 64'(out_miss), 64'(em));
    check_eq({tag, "_colour"}, 64'(colour_o), 64'(ec));
    check_eq({tag, "_count"}, 64'(count), 64'(en));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; chk_valid = 1'b0;
    colour_i = 24'h0; xpixel_i = 32'd0; ypixel_i = 32'd0;
    xpixel_check = 32'd0; ypixel_check = 32'd0;
    do_reset();
    do_reset();

    // Reset state
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_empty", 64'(empty), 64'd1);
    check_eq("rst_full", 64'(full_queue), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_miss", 64'(out_miss), 64'd0);
    check_eq("rst_colour", 64'(colour_o), 64'd0);

    // Basic hit on the second entry (miss in head-only mode)
    push(32'd1, 32'd1, 24'hAA0000);
    push(32'd2, 32'd1, 24'h00BB00);
    check_eq("t1_count2", 64'(count), 64'd2);
    check_eq("t1_empty", 64'(empty), 64'd0);
    req("t1_req21", 32'd2, 32'd1, ANY_MODE, !ANY_MODE,
        ANY_MODE ? 24'h00BB00 : 24'h000000, ANY_MODE ? 3'd1 : 3'd2);
    req("t1_req11", 32'd1, 32'd1, 1'b1, 1'b0, 24'hAA0000, ANY_MODE ? 3'd0 : 3'd1);
    drive(1'b0, 1'b0, ent(32'd0, 32'd0, 24'h0), 1'b0, 32'd0, 32'd0);
    check_eq("t1_idle_valid", 64'(out_valid), 64'd0);
    check_eq("t1_idle_miss", 64'(out_miss), 64'd0);
    check_eq("t1_hold_colour", 64'(colour_o), 64'hAA0000);

    // Request on empty queue
    do_reset();
    req("t2_empty_req", 32'd3, 32'd3, 1'b0, 1'b1, 24'h000000, 3'd0);

    // Fill to DEPTH, drop extra push, full + hit still blocks push
    do_reset();
    for (int i = 0; i < 4; i++) push(32'(10 + i), 32'd20, 24'(i + 1));
    check_eq("t3_count4", 64'(count), 64'd4);
    check_eq("t3_full", 64'(full_queue), 64'd1);
    check_eq("t3_in_ready", 64'(in_ready), 64'd0);
    push(32'd14, 32'd20, 24'h000005);
    check_eq("t3_drop_count", 64'(count), 64'd4);
    drive(1'b0, 1'b1, ent(32'd99, 32'd99, 24'h000099), 1'b1, 32'd10, 32'd20);
    check_eq("t3_fullhit_valid", 64'(out_valid), 64'd1);
    check_eq("t3_fullhit_colour", 64'(colour_o), 64'h000001);
    check_eq("t3_fullhit_count", 64'(count), 64'd3);
    check_eq("t3_fullhit_full", 64'(full_queue), 64'd0);
    req("t3_req99", 32'd99, 32'd99, 1'b0, 1'b1, 24'h000001, 3'd3);
    req("t3_req11", 32'd11, 32'd20, 1'b1, 1'b0, 24'h000002, 3'd2);
    req("t3_req12", 32'd12, 32'd20, 1'b1, 1'b0, 24'h000003, 3'd1);
    req("t3_req13", 32'd13, 32'd20, 1'b1, 1'b0, 24'h000004, 3'd0);
    check_eq("t3_empty", 64'(empty), 64'd1);

    // Push + head hit in the same cycle: new entry lands at index 2
    do_reset();
    push(32'd1, 32'd0, 24'h0000A1);
    push(32'd2, 32'd0, 24'h0000A2);
    push(32'd3, 32'd0, 24'h0000A3);
    drive(1'b0, 1'b1, ent(32'd9, 32'd9, 24'h123456), 1'b1, 32'd1, 32'd0);
    check_eq("t4_valid", 64'(out_valid), 64'd1);
    check_eq("t4_colour", 64'(colour_o), 64'h0000A1);
    check_eq("t4_count", 64'(count), 64'd3);
    req("t4_req2", 32'd2, 32'd0, 1'b1, 1'b0, 24'h0000A2, 3'd2);
    req("t4_req3", 32'd3, 32'd0, 1'b1, 1'b0, 24'h0000A3, 3'd1);
    req("t4_req9", 32'd9, 32'd9, 1'b1, 1'b0, 24'h123456, 3'd0);

    // A same-cycle pushed entry is not matched
    do_reset();
    drive(1'b0, 1'b1, ent(32'd7, 32'd7, 24'h777777), 1'b1, 32'd7, 32'd7);
    check_eq("t5_samecyc_miss", 64'(out_miss), 64'd1);
    check_eq("t5_samecyc_valid", 64'(out_valid), 64'd0);
    check_eq("t5_samecyc_count", 64'(count), 64'd1);
    req("t5_req77", 32'd7, 32'd7, 1'b1, 1'b0, 24'h777777, 3'd0);

    // Duplicate coordinates: oldest first
    push(32'd5, 32'd5, 24'h111111);
    push(32'd5, 32'd5, 24'h222222);
    req("t6_dup_first", 32'd5, 32'd5, 1'b1, 1'b0, 24'h111111, 3'd1);
    req("t6_dup_second", 32'd5, 32'd5, 1'b1, 1'b0, 24'h222222, 3'd0);

    // Middle-entry request: removal + shift, or miss in head-only mode
    do_reset();
    push(32'd1, 32'd1, 24'h0A0A0A);
    push(32'd2, 32'd2, 24'h0B0B0B);
    push(32'd3, 32'd3, 24'h0C0C0C);
    req("t7_req22", 32'd2, 32'd2, ANY_MODE, !ANY_MODE,
        ANY_MODE ? 24'h0B0B0B : 24'h000000, ANY_MODE ? 3'd2 : 3'd3);
    req("t7_req11", 32'd1, 32'd1, 1'b1, 1'b0, 24'h0A0A0A, ANY_MODE ? 3'd1 : 3'd2);
    req("t7_req33", 32'd3, 32'd3, ANY_MODE, !ANY_MODE,
        ANY_MODE ? 24'h0C0C0C : 24'h0A0A0A, ANY_MODE ? 3'd0 : 3'd2);
    req("t7_req22b", 32'd2, 32'd2, !ANY_MODE, ANY_MODE,
        ANY_MODE ? 24'h0C0C0C : 24'h0B0B0B, ANY_MODE ? 3'd0 : 3'd1);

    // Reset wins over same-cycle push and hit
    do_reset();
    push(32'd1, 32'd1, 24'h000001);
    push(32'd2, 32'd2, 24'h000002);
    push(32'd3, 32'd3, 24'h000003);
    check_eq("t8_count3", 64'(count), 64'd3);
    drive(1'b1, 1'b1, ent(32'd4, 32'd4, 24'h000004), 1'b1, 32'd1, 32'd1);
    check_eq("t8_count", 64'(count), 64'd0);
    check_eq("t8_empty", 64'(empty), 64'd1);
    check_eq("t8_out_valid", 64'(out_valid), 64'd0);
    check_eq("t8_out_miss", 64'(out_miss), 64'd0);
    check_eq("t8_colour", 64'(colour_o), 64'd0);
    check_eq("t8_in_ready", 64'(in_ready), 64'd1);
    req("t8_req_after", 32'd1, 32'd1, 1'b0, 1'b1, 24'h000000, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_reorder_queue.md
PIXEL_REORDER_QUEUE -- requirements
Module: pixel_reorder_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the pixel coordinate width.
REQ-002 SHALL have parameter RBG_SIZE, default 24, the colour width.
REQ-003 SHALL have parameter DEPTH, default 8, the entry count (2..64).
REQ-004 SHALL have parameter COUNT_W, default $clog2(DEPTH+1), the occupancy width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: the engine offers a finished pixel.
REQ-008 SHALL have port in_ready, output, 1 bit: the queue accepts it (push = in_valid && in_ready).
REQ-009 SHALL have ports colour_i, xpixel_i and ypixel_i, inputs of RBG_SIZE, DATA_WIDTH and DATA_WIDTH bits: the pushed entry.
REQ-010 SHALL have port chk_valid, input, 1 bit: the combinator requests a coordinate.
REQ-011 SHALL have ports xpixel_check and ypixel_check, inputs of DATA_WIDTH bits each: the requested coordinate.
REQ-012 SHALL have port colour_o, output, RBG_SIZE bits: the matched colour.
REQ-013 SHALL have port out_valid, output, 1 bit: colour_o valid, a 1-cycle pulse.
REQ-014 SHALL have port out_miss, output, 1 bit: a 1-cycle pulse meaning the request found no entry.
REQ-015 SHALL have ports full_queue and empty, outputs, 1 bit each: the occupancy flags.
REQ-016 SHALL have port count, output, COUNT_W bits: the number of valid entries.

Function
REQ-017 SHALL store entries compacted at indices 0..count-1, with index 0 oldest.
REQ-018 SHALL drive in_ready = (count != DEPTH) combinationally, independent of any same-cycle removal.
REQ-019 SHALL compare a request only against stored entries; a same-cycle pushed entry is never matched.
REQ-020 SHALL select the lowest matching index on a hit: the oldest entry wins for duplicate coordinates.
REQ-021 SHALL, on a hit, register colour_o and pulse out_valid one cycle after chk_valid, then shift entries above the hit down one and decrement count.
REQ-022 SHALL, on a miss with chk_valid, pulse out_miss one cycle later; colour_o, the entries and count stay unchanged.
REQ-023 SHALL, on push without a hit, write the entry at index count and increment count.
REQ-024 SHALL, on push with a same-cycle hit, write at index count-1 after the shift; count is unchanged.
REQ-025 SHALL hold colour_o when out_valid=0.
REQ-026 SHALL keep out_valid and out_miss mutually exclusive.
REQ-027 SHALL drive full_queue = (count==DEPTH) and empty = (count==0) from the count register.
REQ-028 SHALL ignore a request when empty and pulse out_miss.
REQ-029 SHALL accept no push when full, even if a hit frees a slot that cycle.
REQ-030 SHALL never overflow or underflow count.

Reset
REQ-031 SHALL, on reset, set count=0, clear all entry valid bits, and drive colour_o=0, out_valid=0, out_miss=0, full_queue=0, empty=1, in_ready=1.
REQ-032 SHALL give reset priority over a same-cycle push or request, discarding both, including reset asserted mid-stream.
REQ-033 SHALL NOT require the entry data storage to be reset; only the valid bits and count are reset.

Configuration
REQ-034 SHALL provide macro PRQ_ANY_MATCH_EN.
REQ-035 SHALL, with PRQ_ANY_MATCH_EN defined, search all entries for a request (out-of-order reorder buffer).
REQ-036 SHALL, without PRQ_ANY_MATCH_EN, compare a request against index 0 only; a non-head match counts as a miss (in-order queue).

Structure
REQ-037 SHALL place typedef prq_entry_t (colour, x, y) and the default width constants in a shared package prq_pkg.
REQ-038 SHALL implement the comparator array and lowest-index priority encoder as sub-module prq_match_unit, producing hit and hit_idx.
REQ-039 SHALL keep pixel_reorder_queue as the storage, shift, count and output register logic only.

Verification (DEPTH=4, PRQ_ANY_MATCH_EN defined unless stated)
REQ-040 SHALL cover: push (1,1,0xAA0000), (2,1,0x00BB00); request (2,1) -> next cycle out_valid=1, colour_o=0x00BB00, count=1.
REQ-041 SHALL cover: push 4 entries -> full_queue=1, in_ready=0; a 5th in_valid is dropped and count stays 4.
REQ-042 SHALL cover: with count=3, a push (9,9,0x123456) and a hit on index 0 in the same cycle -> count=3, new entry at index 2.
REQ-043 SHALL cover: push (5,5,0x111111) twice with different colour 0x222222; request (5,5) -> colour_o=0x111111 first.
REQ-044 SHALL cover: without PRQ_ANY_MATCH_EN, push (1,1), (2,2); request (2,2) -> out_miss=1, count=2.
REQ-045 SHALL cover: with count=3, reset asserted alongside a push and a hit -> count=0, empty=1, out_valid=0 on the next cycle.
